// File: rtl/store_write_buffer.sv
// store_write_buffer
//
// Turns MEM-stage store requests into word-aligned, byte-strobed memory writes.
// It queues them in a DEPTH-entry FIFO and drains them in order to the memory
// write port. It also flags loads whose word matches any pending store.
//
// Optional feature: define STORE_MISALIGN_CHECK_EN to reject misaligned
// half/word stores and size 2'b11. A rejected request is still handshaken but
// is not enqueued, and `err` pulses on the next cycle. When the macro is
// undefined, the ignored address bits are dropped, size 2'b11 acts as a word
// store, and `err` is tied to 0.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid and
// ready are both 1. Valid never depends on ready. A producer holds its payload
// stable while valid is high and ready is low.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/ready     store request handshake (ready = !full, registered count)
//   req_addr/size/data  byte address, size (00 B, 01 H, 10 W, 11 rsvd), value
//   mem_wvalid/wready   head-entry handshake toward memory (valid = !empty)
//   mem_waddr/wdata/    head entry: word address, lane-aligned data,
//   mem_wstrb           and byte strobes
//   ld_addr, ld_hazard  load address; 1 when a pending store covers its word
//   empty               no pending entries
//   err                 one-cycle pulse after a rejected request
module store_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_data,
   output logic        mem_wvalid,
   input  logic        mem_wready,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] ld_addr,
   output logic        ld_hazard,
   output logic        empty,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [31:0] waddr_q [DEPTH];
   logic [31:0] wdata_q [DEPTH];
   logic [3:0]  wstrb_q [DEPTH];
   logic [DEPTH-1:0] vld_q;

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;

   logic [3:0]  al_strb;
   logic [31:0] al_data;
   logic        bad_req;
   logic        hs, push, pop;

   // Only the word part of the load address takes part in the hazard compare.
   logic unused_ld_lsb;
   assign unused_ld_lsb = ^ld_addr[1:0];

   // Lane alignment of the incoming store.
   always_comb begin
      al_strb = 4'b1111;
      al_data = req_data;
      case (req_size)
         2'b00: begin
            al_strb = 4'b0001 << req_addr[1:0];
            al_data = {4{req_data[7:0]}};
         end
         2'b01: begin
            al_strb = req_addr[1] ? 4'b1100 : 4'b0011;
            al_data = {2{req_data[15:0]}};
         end
         default: begin
            al_strb = 4'b1111;
            al_data = req_data;
         end
      endcase
   end

`ifdef STORE_MISALIGN_CHECK_EN
   always_comb begin
      bad_req = 1'b0;
      case (req_size)
         2'b01:   bad_req = req_addr[0];
         2'b10:   bad_req = (req_addr[1:0] != 2'b00);
         2'b11:   bad_req = 1'b1;
         default: bad_req = 1'b0;
      endcase
   end
`else
   assign bad_req = 1'b0;
`endif

   assign req_ready  = (count_q != CNT_FULL);
   assign empty      = (count_q == '0);
   assign mem_wvalid = !empty;

   assign hs   = req_valid && req_ready;
   assign push = hs && !bad_req;
   assign pop  = mem_wvalid && mem_wready;

   assign mem_waddr = waddr_q[rd_ptr_q];
   assign mem_wdata = wdata_q[rd_ptr_q];
   assign mem_wstrb = wstrb_q[rd_ptr_q];

   // Conservative hazard: any valid entry in the same word, strobes ignored.
   // The entry being popped this cycle is still valid here.
   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (waddr_q[i][31:2] == ld_addr[31:2])) begin
            ld_hazard = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            waddr_q[i] <= '0;
            wdata_q[i] <= '0;
            wstrb_q[i] <= '0;
         end
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            waddr_q[wr_ptr_q] <= {req_addr[31:2], 2'b00};
            wdata_q[wr_ptr_q] <= al_data;
            wstrb_q[wr_ptr_q] <= al_strb;
            wr_ptr_q          <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         // Pointers differ whenever both are active, so set/clear never collide.
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr_q == AW'(i))) begin
               vld_q[i] <= 1'b1;
            end else if (pop && (rd_ptr_q == AW'(i))) begin
               vld_q[i] <= 1'b0;
            end
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef STORE_MISALIGN_CHECK_EN
   logic err_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= hs && bad_req;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
